mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
// - Second-generation multicycle RV32I main control FSM. Sequences fetch, decode, execute, memory and writeback.
// - Adds over the first generation: async active-low reset; memory ready/req handshake with wait states;
//   a parametrised wait-timeout counter; a dedicated JALR path; a safe sticky ERROR state (no X outputs);
//   a retire pulse and a state debug bus.
// - Sits in the multicycle core between the IR opcode field and the datapath muxes, ALU decoder and PC logic.
// PARAMETERS
// - MEM_HANDSHAKE   1    1: FETCH/MEMREAD/MEMWRITE wait for mem_ready. 0: mem_ready is ignored (treated as 1).
// - TIMEOUT_W       8    width of the wait-cycle counter.
// - TIMEOUT_CYCLES  200  consecutive not-ready cycles that trigger ERROR with err_timeout. 0 disables the timeout.
// PORTS
// - clk          in   1  clock; all state updates on posedge.
// - reset_n      in   1  asynchronous, active-low reset.
// - op           in   7  IR opcode, instr[6:0]; stable from DECODE onward.
// - mem_ready    in   1  memory has completed the current mem_req access this cycle.
// - mem_req      out  1  memory access requested (FETCH, MEMREAD, MEMWRITE).
// - branch       out  1  conditional PC update enable (BEQ).
// - pcupdate     out  1  unconditional PC write.
// - regwrite     out  1  register file write.
// - memwrite     out  1  data memory write.
// - irwrite      out  1  IR/OldPC capture.
// - resultsrc    out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
// - alusrca      out  2  00 PC, 01 OldPC, 10 rs1.
// - alusrcb      out  2  00 rs2, 01 ImmExt, 10 const 4.
// - adrsrc       out  1  0 PC, 1 Result.
// - aluop        out  2  00 add, 01 sub/compare, 10 funct-decoded.
// - retire       out  1  one-cycle pulse in the final cycle of each instruction.
// - err_illegal  out  1  sticky; set on an unknown opcode.
// - err_timeout  out  1  sticky; set on a memory wait timeout.
// - state_dbg    out  4  current state encoding.
// BEHAVIOUR
// - Reset (reset_n=0): state=FETCH, wait counter=0, err_*=0; all strobes and selects forced to 0 while reset_n is low.
// - Outputs are Moore (from the state), except that stall gating uses mem_ready combinationally.
// - States and transitions:
//   - FETCH: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, resultsrc=10.
//     irwrite=pcupdate=ready. Goes to DECODE on ready, else stays.
//   - DECODE: alusrca=01, alusrcb=01 (branch/JAL target into ALUOut). Dispatch on op:
//     0110011 EXECR; 0010011 EXECI; 0000011/0100011 MEMADR; 1100011 BEQ; 1101111 JAL;
//     1100111 MEMADR; 0010111 AUIPC; 0110111 LUI; anything else goes to ERROR and sets err_illegal.
//   - MEMADR: alusrca=10, alusrcb=01. Next state: MEMREAD if op=0000011, MEMWRITE if op=0100011, JALR if op=1100111.
//   - MEMREAD: mem_req=1, adrsrc=1, resultsrc=00. Goes to MEMWB on ready.
//   - MEMWB: regwrite=1, resultsrc=01, retire=1. Goes to FETCH.
//   - MEMWRITE: mem_req=1, adrsrc=1, memwrite=ready, retire=ready. Goes to FETCH on ready.
//   - EXECR: alusrca=10, alusrcb=00, aluop=10. Goes to ALUWB.
//   - EXECI: alusrca=10, alusrcb=01, aluop=10. Goes to ALUWB.
//   - ALUWB: regwrite=1, resultsrc=00, retire=1. Goes to FETCH.
//   - JAL/JALR: pcupdate=1, resultsrc=00 (target), alusrca=01, alusrcb=10 (OldPC+4). Goes to ALUWB.
//   - BEQ: branch=1, alusrca=10, alusrcb=00, aluop=01, resultsrc=00, retire=1. Goes to FETCH.
//   - AUIPC: alusrca=01, alusrcb=01. Goes to ALUWB.
//   - LUI: regwrite=1, resultsrc=11, retire=1. Goes to FETCH.
//   - ERROR: all strobes 0, selects 00. Stays in ERROR until reset; the err_* flags hold.
// - Zero-wait instruction latency in cycles: lw 5, sw 4, R/I 4, jal 4, jalr 5, auipc 4, beq 3, lui 3.
// - Wait counter:
//   - Increments each cycle in which mem_req=1 and mem_ready=0.
//   - Clears on a ready cycle and on every state change.
//   - Saturates at 2^TIMEOUT_W-1.
//   - When the count reaches TIMEOUT_CYCLES-1 and mem_ready=0, the next state is ERROR and err_timeout is set.
//   - If mem_ready=1 in the same cycle as the timeout condition, ready wins: the access completes and no error is raised.
// - A mid-instruction reset abandons the instruction. No write strobe may be high in the reset cycle.
// STRUCTURE
// - Package mc_ctrl_pkg holds:
//   - the state_t enum (4-bit, FETCH=0);
//   - opcode localparams OP_RTYPE, OP_IARITH, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI;
//   - select localparams for resultsrc, alusrca, alusrcb and aluop.
// - One sub-module, mc_wait_timer (TIMEOUT_W, TIMEOUT_CYCLES):
//   - inputs: clk, reset_n, active, ready, clr;
//   - output: expired.
// - The FSM itself is one always_ff (state, flags) plus two always_comb blocks (next state, outputs).
// TESTING
// - Reset: hold reset_n=0 mid-MEMWRITE with mem_ready=1.
//   -> memwrite=0 immediately; state_dbg=0 after release; err_*=0.
// - Zero-wait lw (op=0000011): retire arrives exactly 5 cycles after leaving reset.
//   Sequence: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, with regwrite=1 and resultsrc=01 in MEMWB.
// - Wait states: hold mem_ready=0 for 3 cycles in FETCH.
//   -> irwrite=pcupdate=0 for those 3 cycles, then 1 for one cycle. Total lw latency is 8.
// - Timeout: TIMEOUT_CYCLES=4, mem_ready held at 0 in MEMREAD.
//   -> ERROR after 4 wait cycles; err_timeout=1; all strobes 0 for 20 further cycles.
// - Illegal opcode: op=1111111.
//   -> DECODE goes to ERROR; err_illegal=1 and sticky; recovery only after a reset_n pulse.
// - jalr (op=1100111): sequence FETCH, DECODE, MEMADR, JALR, ALUWB.
//   pcupdate=1 only in FETCH and JALR; regwrite=1 only in ALUWB; 5 cycles total.
//   beq: 3 cycles, with branch=1 and aluop=01 in BEQ.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I main control FSM.
//   state_t      : 4-bit state encoding, FETCH is 0 so a reset state reads as zero on state_dbg
//   OP_*         : RV32I major opcodes (instr[6:0]) the controller dispatches on
//   RES_/SRCA_/SRCB_/ALUOP_* : datapath select encodings driven by the FSM
//   decode_op()  : DECODE dispatch table, opcode -> first execute-phase state
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_BEQ      = 4'd11,
    S_AUIPC    = 4'd12,
    S_LUI      = 4'd13,
    S_ERROR    = 4'd14
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Unknown opcodes map to S_ERROR; the caller raises err_illegal on that result.
  function automatic state_t decode_op(input logic [6:0] opcode);
    state_t nxt;
    case (opcode)
      OP_RTYPE:          nxt = S_EXECR;
      OP_IARITH:         nxt = S_EXECI;
      OP_LOAD, OP_STORE: nxt = S_MEMADR;
      OP_BRANCH:         nxt = S_BEQ;
      OP_JAL:            nxt = S_JAL;
      OP_JALR:           nxt = S_MEMADR;
      OP_AUIPC:          nxt = S_AUIPC;
      OP_LUI:            nxt = S_LUI;
      default:           nxt = S_ERROR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state timer.
//   clk, reset_n : clock, asynchronous active-low reset
//   active       : a memory access is being requested this cycle
//   ready        : memory completes the access this cycle
//   clr          : controller changes state this cycle (restart the count)
//   expired      : this is the last tolerated not-ready cycle; controller must abort
// The count saturates so a long stall with the timeout disabled never wraps.
module mc_wait_timer #(
  parameter int unsigned TIMEOUT_W      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  input  logic ready,
  input  logic clr,
  output logic expired
);

  localparam bit                   TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] CntMax    = '1;
  localparam logic [TIMEOUT_W-1:0] CntLimit  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr || ready) begin
      count_d = '0;
    end else if (active && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A ready in the same cycle always wins over the timeout.
  assign expired = TimeoutEn && active && !ready && (count_q == CntLimit);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I main control FSM (second generation).
//   clk, reset_n  : clock, asynchronous active-low reset
//   op            : IR opcode, stable from DECODE onward
//   mem_ready     : memory completes the current mem_req access
//   mem_req       : memory access requested (FETCH, MEMREAD, MEMWRITE)
//   branch, pcupdate, regwrite, memwrite, irwrite : datapath strobes
//   resultsrc, alusrca, alusrcb, adrsrc, aluop    : datapath selects
//   retire        : pulse in the final cycle of each instruction
//   err_illegal   : sticky, unknown opcode seen
//   err_timeout   : sticky, memory wait timed out
//   state_dbg     : current state encoding
// Outputs are decoded from the state; only the FETCH/MEMWRITE completion strobes look at
// mem_ready combinationally. Everything is forced low while reset_n is low.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE  = 1'b1,
  parameter int unsigned TIMEOUT_W      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       branch,
  output logic       pcupdate,
  output logic       regwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       adrsrc,
  output logic [1:0] aluop,
  output logic       retire,
  output logic       err_illegal,
  output logic       err_timeout,
  output logic [3:0] state_dbg
);

  state_t state_q, state_d;
  logic   err_illegal_q, err_timeout_q;
  logic   set_illegal, set_timeout;
  logic   ready, expired, state_chg;

  assign ready     = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state_chg = (state_d != state_q);

  mc_wait_timer #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (mem_req),
    .ready   (ready),
    .clr     (state_chg),
    .expired (expired)
  );

  // Next state.
  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    unique case (state_q)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (ready) begin
          unique case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_MEMREAD: state_d = S_MEMWB;
            default:   state_d = S_FETCH;
          endcase
        end else if (expired) begin
          state_d     = S_ERROR;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        state_d     = decode_op(op);
        set_illegal = (state_d == S_ERROR);
      end
      S_MEMADR: begin
        case (op)
          OP_LOAD:  state_d = S_MEMREAD;
          OP_STORE: state_d = S_MEMWRITE;
          OP_JALR:  state_d = S_JALR;
          // Opcode changed after DECODE: treat like an illegal instruction.
          default: begin
            state_d     = S_ERROR;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_EXECR, S_EXECI, S_JAL, S_JALR, S_AUIPC: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_LUI:           state_d = S_FETCH;
      S_ERROR:                                  state_d = S_ERROR;
      default:                                  state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_FETCH;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) err_illegal_q <= 1'b1;
      if (set_timeout) err_timeout_q <= 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    mem_req   = 1'b0;
    branch    = 1'b0;
    pcupdate  = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    resultsrc = RES_ALUOUT;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RS2;
    adrsrc    = 1'b0;
    aluop     = ALUOP_ADD;
    retire    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURES;
        irwrite   = ready;
        pcupdate  = ready;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req   = 1'b1;
        adrsrc    = 1'b1;
        resultsrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        regwrite  = 1'b1;
        resultsrc = RES_DATA;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        adrsrc   = 1'b1;
        memwrite = ready;
        retire   = ready;
      end
      S_EXECR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_RS2;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite  = 1'b1;
        resultsrc = RES_ALUOUT;
        retire    = 1'b1;
      end
      // Jump target was computed into ALUOut in DECODE/MEMADR; ALU now forms OldPC+4.
      S_JAL, S_JALR: begin
        pcupdate  = 1'b1;
        resultsrc = RES_ALUOUT;
        alusrca   = SRCA_OLDPC;
        alusrcb   = SRCB_FOUR;
      end
      S_BEQ: begin
        branch    = 1'b1;
        alusrca   = SRCA_RS1;
        alusrcb   = SRCB_RS2;
        aluop     = ALUOP_SUB;
        resultsrc = RES_ALUOUT;
        retire    = 1'b1;
      end
      S_AUIPC: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      S_LUI: begin
        regwrite  = 1'b1;
        resultsrc = RES_IMM;
        retire    = 1'b1;
      end
      default: ;
    endcase
    // Async reset must kill write strobes in the same cycle it is asserted.
    if (!reset_n) begin
      mem_req   = 1'b0;
      branch    = 1'b0;
      pcupdate  = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      resultsrc = 2'b00;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      adrsrc    = 1'b0;
      aluop     = 2'b00;
      retire    = 1'b0;
    end
  end

  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic       clk, reset_n, mem_ready;
  logic [6:0] op;
  logic       mem_req, branch, pcupdate, regwrite, memwrite, irwrite, adrsrc, retire;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;
  logic       err_illegal, err_timeout;
  logic [3:0] state_dbg;

  mc_ctrl_fsm #(
    .MEM_HANDSHAKE  (1'b1),
    .TIMEOUT_W      (8),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op          (op),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .branch      (branch),
    .pcupdate    (pcupdate),
    .regwrite    (regwrite),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .resultsrc   (resultsrc),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .adrsrc      (adrsrc),
    .aluop       (aluop),
    .retire      (retire),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] outs = {mem_req, branch, pcupdate, regwrite, memwrite, irwrite, resultsrc,
                      alusrca, alusrcb, adrsrc, aluop, retire};

  // Opcodes as written in the ISA.
  localparam logic [6:0] L_R = 7'b0110011, L_I = 7'b0010011, L_LW = 7'b0000011;
  localparam logic [6:0] L_SW = 7'b0100011, L_BEQ = 7'b1100011, L_JAL = 7'b1101111;
  localparam logic [6:0] L_JALR = 7'b1100111, L_AUIPC = 7'b0010111, L_LUI = 7'b0110111;
  logic [6:0] ops [9] = '{L_R, L_I, L_LW, L_SW, L_BEQ, L_JAL, L_JALR, L_AUIPC, L_LUI};

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Per-instruction summary: what an instruction should look like at the pins.
  typedef struct packed {
    logic [7:0] cyc;
    logic [3:0] mreq;
    logic [3:0] rgw;
    logic [3:0] mw;
    logic [3:0] pcu;
    logic [3:0] brn;
    logic [3:0] irw;
    logic [1:0] res;
  } rec_t;

  rec_t exp_q[$];
  int   wq[$];
  bit   scb_on = 1'b0;

  // Monitor: accumulate pin activity, compare at each retire.
  int m_cyc = 0, m_mreq = 0, m_rgw = 0, m_mw = 0, m_pcu = 0, m_brn = 0, m_irw = 0;
  always begin
    rec_t got, want;
    @(negedge clk);
    #2;
    if (!scb_on || !reset_n) begin
      m_cyc = 0; m_mreq = 0; m_rgw = 0; m_mw = 0; m_pcu = 0; m_brn = 0; m_irw = 0;
    end else begin
      m_cyc++;
      m_mreq += int'(mem_req); m_rgw += int'(regwrite); m_mw += int'(memwrite);
      m_pcu  += int'(pcupdate); m_brn += int'(branch); m_irw += int'(irwrite);
      if (retire) begin
        got.cyc = 8'(m_cyc); got.mreq = 4'(m_mreq); got.rgw = 4'(m_rgw); got.mw = 4'(m_mw);
        got.pcu = 4'(m_pcu); got.brn = 4'(m_brn); got.irw = 4'(m_irw); got.res = resultsrc;
        if (exp_q.size() == 0) begin
          check("scb_unexpected_retire", 64'(got), 64'(0));
        end else begin
          want = exp_q.pop_front();
          check("scb_instr", 64'(got), 64'(want));
        end
        m_cyc = 0; m_mreq = 0; m_rgw = 0; m_mw = 0; m_pcu = 0; m_brn = 0; m_irw = 0;
      end else if (m_cyc > 40) begin
        check("scb_no_retire", 64'(m_cyc), 64'(0));
        m_cyc = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic cyc(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask

  // Reference: latency and pin activity from the instruction class and wait counts.
  task automatic issue();
    rec_t e;
    logic [6:0] o;
    int fw, dw, cy, mr;
    o  = ops[$urandom_range(0, 8)];
    fw = $urandom_range(0, 3);
    dw = $urandom_range(0, 3);
    e  = '0;
    e.irw = 4'd1;
    e.pcu = 4'd1;
    cy = fw;
    mr = 1 + fw;
    case (o)
      L_LW:    begin cy += 5 + dw; mr += 1 + dw; e.rgw = 4'd1; e.res = 2'b01; end
      L_SW:    begin cy += 4 + dw; mr += 1 + dw; e.mw = 4'd1; end
      L_R:     begin cy += 4; e.rgw = 4'd1; end
      L_I:     begin cy += 4; e.rgw = 4'd1; end
      L_JAL:   begin cy += 4; e.rgw = 4'd1; e.pcu = 4'd2; end
      L_JALR:  begin cy += 5; e.rgw = 4'd1; e.pcu = 4'd2; end
      L_AUIPC: begin cy += 4; e.rgw = 4'd1; end
      L_BEQ:   begin cy += 3; e.brn = 4'd1; end
      default: begin cy += 3; e.rgw = 4'd1; e.res = 2'b11; end
    endcase
    e.cyc  = 8'(cy);
    e.mreq = 4'(mr);
    wq.push_back(fw);
    if (o == L_LW || o == L_SW) wq.push_back(dw);
    exp_q.push_back(e);
    op = o;
  endtask

  // Directed trace capture.
  logic [31:0] tr_seq;
  logic [15:0] tr_pcu, tr_rgw, tr_irw, tr_brn;
  logic [1:0]  tr_res, tr_aluop;
  int          tr_lat;

  task automatic run_trace(input logic [6:0] o, input int fwaits);
    op = o;
    do_reset();
    tr_seq = '0; tr_pcu = '0; tr_rgw = '0; tr_irw = '0; tr_brn = '0;
    tr_res = '0; tr_aluop = '0; tr_lat = 0;
    for (int c = 0; c < 30; c++) begin
      cyc((c < fwaits) ? 1'b0 : 1'b1);
      tr_seq = {tr_seq[27:0], state_dbg};
      tr_pcu = {tr_pcu[14:0], pcupdate};
      tr_rgw = {tr_rgw[14:0], regwrite};
      tr_irw = {tr_irw[14:0], irwrite};
      tr_brn = {tr_brn[14:0], branch};
      if (branch) tr_aluop = aluop;
      if (retire) begin
        tr_lat = c + 1;
        tr_res = resultsrc;
        break;
      end
    end
  endtask

  initial begin
    int bad, n_done, guard, left;
    bit in_acc;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    op        = L_SW;

    // Reset state.
    #12;
    check("rst_outs_low", 64'(outs), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    check("rst_errs", 64'({err_illegal, err_timeout}), 64'(0));

    // Zero-wait lw.
    run_trace(L_LW, 0);
    check("lw_latency", 64'(tr_lat), 64'(5));
    check("lw_seq", 64'(tr_seq[19:0]), 64'({S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB}));
    check("lw_regwrite", 64'(tr_rgw[4:0]), 64'(5'b00001));
    check("lw_resultsrc", 64'(tr_res), 64'(2'b01));

    // Three fetch wait states.
    run_trace(L_LW, 3);
    check("lw_wait_latency", 64'(tr_lat), 64'(8));
    check("lw_wait_irwrite", 64'(tr_irw[7:0]), 64'(8'b0001_0000));
    check("lw_wait_pcupdate", 64'(tr_pcu[7:0]), 64'(8'b0001_0000));

    // jalr and beq.
    run_trace(L_JALR, 0);
    check("jalr_latency", 64'(tr_lat), 64'(5));
    check("jalr_seq", 64'(tr_seq[19:0]), 64'({S_FETCH, S_DECODE, S_MEMADR, S_JALR, S_ALUWB}));
    check("jalr_pcupdate", 64'(tr_pcu[4:0]), 64'(5'b10010));
    check("jalr_regwrite", 64'(tr_rgw[4:0]), 64'(5'b00001));
    run_trace(L_BEQ, 0);
    check("beq_latency", 64'(tr_lat), 64'(3));
    check("beq_branch", 64'(tr_brn[2:0]), 64'(3'b001));
    check("beq_aluop", 64'(tr_aluop), 64'(2'b01));

    // Reset asserted mid-MEMWRITE with mem_ready high.
    op = L_SW;
    do_reset();
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    cyc(1'b1);
    check("sw_in_memwrite", 64'(state_dbg), 64'(S_MEMWRITE));
    check("sw_memwrite_pre", 64'(memwrite), 64'(1));
    reset_n = 1'b0;
    #1;
    check("rst_mid_memwrite", 64'(memwrite), 64'(0));
    check("rst_mid_outs", 64'(outs), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1'b1);
    check("rst_mid_state", 64'(state_dbg), 64'(0));
    check("rst_mid_errs", 64'({err_illegal, err_timeout}), 64'(0));

    // Ready on the last tolerated wait cycle completes the read.
    op = L_LW;
    do_reset();
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
    cyc(1'b1);
    check("ready_wins_state", 64'(state_dbg), 64'(S_MEMWB));
    check("ready_wins_err", 64'(err_timeout), 64'(0));

    // Timeout in MEMREAD.
    do_reset();
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0);
      if (state_dbg != S_MEMREAD) bad++;
    end
    check("to_wait_cycles", 64'(bad), 64'(0));
    cyc(1'b0);
    check("to_state", 64'(state_dbg), 64'(S_ERROR));
    check("to_flag", 64'({err_illegal, err_timeout}), 64'(2'b01));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom_range(0, 1)));
      if (outs != 16'd0 || state_dbg != S_ERROR || !err_timeout) bad++;
    end
    check("to_hold", 64'(bad), 64'(0));

    // Illegal opcode.
    op = 7'b1111111;
    do_reset();
    cyc(1'b1); cyc(1'b1);
    check("ill_decode", 64'(state_dbg), 64'(S_DECODE));
    cyc(1'b1);
    check("ill_state", 64'(state_dbg), 64'(S_ERROR));
    check("ill_flag", 64'({err_illegal, err_timeout}), 64'(2'b10));
    op  = L_LW;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom_range(0, 1)));
      if (outs != 16'd0 || state_dbg != S_ERROR || !err_illegal) bad++;
    end
    check("ill_sticky", 64'(bad), 64'(0));
    do_reset();
    cyc(1'b1);
    check("ill_recover", 64'({state_dbg, err_illegal}), 64'(0));

    // Randomized instruction stream against the scoreboard.
    do_reset();
    scb_on = 1'b1;
    issue();
    n_done = 0;
    guard  = 0;
    left   = 0;
    in_acc = 1'b0;
    while (n_done < 150 && guard < 5000) begin
      guard++;
      @(negedge clk);
      if (mem_req) begin
        if (!in_acc) begin
          left   = (wq.size() != 0) ? wq.pop_front() : 0;
          in_acc = 1'b1;
        end
        if (left > 0) begin
          mem_ready = 1'b0;
          left--;
        end else begin
          mem_ready = 1'b1;
          in_acc    = 1'b0;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (retire) begin
        n_done++;
        if (n_done < 150) issue();
      end
    end
    @(negedge clk);
    #3;
    scb_on = 1'b0;
    check("scb_retired", 64'(n_done), 64'(150));
    check("scb_drained", 64'(exp_q.size()), 64'(0));
    check("scb_no_errs", 64'({err_illegal, err_timeout}), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
